lcd_text_engine: RTL

- Parametrised successor to the hard-coded character-LCD sequencer: drives an HD44780-class 8-bit parallel LCD from an internal ROWS x COLS character buffer.
- Runs the power-up init, then refreshes the whole screen on request.
- Timing is set by cycle-count parameters, not fixed step numbers.
- Sits between page/menu logic (writes the buffer, pulses refresh) and the LCD pins.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_text_engine_byte_writer.sv | 88 ++++++++
 rtl/lcd_text_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD text engine: HD44780 command codes,
// DDRAM row addressing and the sequencer state encoding.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    REFRESH_ADDR,
    REFRESH_CHAR
  } lcd_state_e;

  // Rows 2/3 of a 4-line panel continue rows 0/1 in DDRAM, offset by the row length.
  function automatic logic [7:0] row_offset(input logic [1:0] row, input int cols);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(cols);
      default: return 8'(8'h40 + cols);
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_8B2L;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY_INC;
      default: return LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_engine_byte_writer.sv
// One LCD bus transfer: SETUP (data valid, E low), PULSE (E high), WAIT (E low,
// controller executing). done marks the last WAIT cycle so a new start can follow directly.
module lcd_byte_writer #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 25,
  parameter int EXEC_CYC  = 2000,
  parameter int CLEAR_CYC = 80000
) (
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic       start,
  input  logic       is_data,
  input  logic [7:0] data_byte,
  input  logic       long_wait,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_enable
);

  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B = (EXEC_CYC > CLEAR_CYC) ? EXEC_CYC : CLEAR_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_PULSE = 2'd2;
  localparam logic [1:0] PH_WAIT  = 2'd3;

  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  logic          long_q;
  logic          wait_last;

  assign wait_last = (cnt == (long_q ? CW'(CLEAR_CYC - 1) : CW'(EXEC_CYC - 1)));
  assign done      = (phase == PH_WAIT) && wait_last;

  // Data and RS are only loaded on start, so they stay frozen across E high.
  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      phase      <= PH_IDLE;
      cnt        <= '0;
      long_q     <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_enable <= 1'b0;
    end else if (start) begin
      phase      <= PH_SETUP;
      cnt        <= '0;
      long_q     <= long_wait;
      lcd_data   <= data_byte;
      lcd_rs     <= is_data;
      lcd_enable <= 1'b0;
    end else begin
      case (phase)
        PH_SETUP: begin
          if (cnt == CW'(SETUP_CYC - 1)) begin
            phase      <= PH_PULSE;
            cnt        <= '0;
            lcd_enable <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_PULSE: begin
          if (cnt == CW'(PULSE_CYC - 1)) begin
            phase      <= PH_WAIT;
            cnt        <= '0;
            lcd_enable <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_WAIT: begin
          if (wait_last) begin
            phase <= PH_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_engine.sv
// Character-LCD text engine: power-up delay, HD44780 init, then full-screen redraws
// of an internal ROWS x COLS buffer on request.
module lcd_text_engine
  import lcd_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 25,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 80000,
  parameter int POWERUP_CYC = 750000
) (
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic       buf_wr_en_i,
  input  logic [1:0] buf_wr_row_i,
  input  logic [4:0] buf_wr_col_i,
  input  logic [7:0] buf_wr_char_i,
  input  logic       refresh_i,
  output logic       busy_o,
  output logic       valid_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_enable_o
);

  localparam int PU_W = $clog2(POWERUP_CYC + 1);

  lcd_state_e      state, state_n;
  logic [PU_W-1:0] pu_cnt;
  logic [1:0]      init_idx, idx_n;
  logic [1:0]      row, row_n;
  logic [4:0]      col, col_n;
  logic [4:0]      rd_col;
  logic [7:0]      rd_char;
  logic            pending;
  logic            start, wr_is_data, done;
  logic [7:0]      wr_byte;

  // Full 4x32 array keeps index widths exact; cells outside the window are never written or shown.
  logic [7:0] char_buf [4][32];

  assign busy_o  = (state != IDLE);
  assign rd_col  = (state == REFRESH_CHAR) ? col + 5'd1 : 5'd0;
  assign rd_char = char_buf[row][rd_col];

  always_comb begin
    state_n    = state;
    idx_n      = init_idx;
    row_n      = row;
    col_n      = col;
    start      = 1'b0;
    wr_byte    = 8'h00;
    wr_is_data = 1'b0;
    case (state)
      POWERUP: begin
        if (pu_cnt == PU_W'(POWERUP_CYC - 1)) begin
          start   = 1'b1;
          wr_byte = init_cmd(2'd0);
          idx_n   = 2'd0;
          state_n = INIT;
        end
      end
      INIT: begin
        if (done) begin
          start = 1'b1;
          if (init_idx == 2'd3) begin
            wr_byte = LCD_SET_DDRAM | row_offset(2'd0, COLS);
            row_n   = 2'd0;
            state_n = REFRESH_ADDR;
          end else begin
            wr_byte = init_cmd(init_idx + 2'd1);
            idx_n   = init_idx + 2'd1;
          end
        end
      end
      IDLE: begin
        if (refresh_i || pending) begin
          start   = 1'b1;
          wr_byte = LCD_SET_DDRAM | row_offset(2'd0, COLS);
          row_n   = 2'd0;
          state_n = REFRESH_ADDR;
        end
      end
      REFRESH_ADDR: begin
        if (done) begin
          start      = 1'b1;
          wr_byte    = rd_char;
          wr_is_data = 1'b1;
          col_n      = 5'd0;
          state_n    = REFRESH_CHAR;
        end
      end
      REFRESH_CHAR: begin
        if (done) begin
          if (col != 5'(COLS - 1)) begin
            start      = 1'b1;
            wr_byte    = rd_char;
            wr_is_data = 1'b1;
            col_n      = col + 5'd1;
          end else if (row != 2'(ROWS - 1)) begin
            start   = 1'b1;
            wr_byte = LCD_SET_DDRAM | row_offset(row + 2'd1, COLS);
            row_n   = row + 2'd1;
            state_n = REFRESH_ADDR;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = POWERUP;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      state    <= POWERUP;
      pu_cnt   <= '0;
      init_idx <= 2'd0;
      row      <= 2'd0;
      col      <= 5'd0;
      pending  <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      state    <= state_n;
      init_idx <= idx_n;
      row      <= row_n;
      col      <= col_n;
      if (state == POWERUP) pu_cnt <= pu_cnt + 1'b1;
      // Requests during power-up/init are covered by the automatic first refresh.
      if (state == IDLE) pending <= 1'b0;
      else if (refresh_i && (state == REFRESH_ADDR || state == REFRESH_CHAR)) pending <= 1'b1;
      if (state == REFRESH_CHAR && state_n == IDLE) valid_o <= 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 32; c++)
          char_buf[r][c] <= 8'h20;
    end else if (buf_wr_en_i && int'(buf_wr_row_i) < ROWS && int'(buf_wr_col_i) < COLS) begin
      char_buf[buf_wr_row_i][buf_wr_col_i] <= buf_wr_char_i;
    end
  end

  lcd_byte_writer #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .EXEC_CYC  (EXEC_CYC),
    .CLEAR_CYC (CLEAR_CYC)
  ) u_writer (
    .fpga_clk_i   (fpga_clk_i),
    .fpga_reset_i (fpga_reset_i),
    .start        (start),
    .is_data      (wr_is_data),
    .data_byte    (wr_byte),
    .long_wait    (!wr_is_data && wr_byte == LCD_CLEAR),
    .done         (done),
    .lcd_data     (lcd_data_o),
    .lcd_rs       (lcd_rs_o),
    .lcd_enable   (lcd_enable_o)
  );

endmodule
